// File: rtl/dense_logit_layer.sv
// Four-neuron fully-connected output layer: streamed int8 MAC, arithmetic scale, saturate to int8 logits.
// Optional per-neuron bias preload is compiled in with the DENSE_BIAS_EN macro.
module dense_logit_layer #(
    parameter int N_IN  = 8,
    parameter int ACC_W = 20,
    parameter int SHIFT = 7,
    localparam int AW   = $clog2(4 * N_IN + 4)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_we,
    input  logic [AW-1:0]       w_addr,
    input  logic signed [7:0]   w_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [7:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [7:0]   logit0,
    output logic signed [7:0]   logit1,
    output logic signed [7:0]   logit2,
    output logic signed [7:0]   logit3,
    output logic                busy
);

    localparam int NW   = 4 * N_IN;
    localparam int WIDX = $clog2(NW);
    localparam int IW   = $clog2(N_IN);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32'sd127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32'sd128);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        SCALE = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [IW-1:0]           idx_q;
    logic signed [7:0]       w_q       [NW];
    logic signed [ACC_W-1:0] acc_q     [4];
    logic signed [ACC_W-1:0] acc_d     [4];
    logic signed [ACC_W-1:0] preload_s [4];
    logic signed [15:0]      prod_s    [4];
    logic signed [7:0]       logit_q   [4];
    logic signed [7:0]       logit_d   [4];
    logic                    out_valid_q;
    logic                    hs_s;
    logic                    wr_en_s;
    logic                    wr_weight_s;
`ifdef DENSE_BIAS_EN
    logic signed [7:0]       bias_q    [4];
    logic [AW-1:0]           bias_off_s;
    logic                    wr_bias_s;
`endif

    // Floor-shift (>>> rounds toward -inf) then clamp into the int8 logit range.
    function automatic logic signed [7:0] scale_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s > SAT_HI) begin
            return 8'sd127;
        end else if (s < SAT_LO) begin
            return -8'sd128;
        end else begin
            return s[7:0];
        end
    endfunction

    assign in_ready    = (state_q == IDLE) || (state_q == ACC);
    assign busy        = (state_q != IDLE);
    assign out_valid   = out_valid_q;
    assign logit0      = logit_q[0];
    assign logit1      = logit_q[1];
    assign logit2      = logit_q[2];
    assign logit3      = logit_q[3];
    assign hs_s        = in_valid && in_ready;
    assign wr_en_s     = w_we && (state_q == IDLE);
    assign wr_weight_s = wr_en_s && (w_addr < AW'(NW));
`ifdef DENSE_BIAS_EN
    assign bias_off_s  = w_addr - AW'(NW);
    assign wr_bias_s   = wr_en_s && (w_addr >= AW'(NW)) && (bias_off_s < AW'(4));
`endif

    // MAC next-state and scaled logits; the first element starts from the preload, not acc_q.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
`ifdef DENSE_BIAS_EN
            preload_s[k] = ACC_W'(bias_q[k]) <<< SHIFT;
`else
            preload_s[k] = '0;
`endif
            prod_s[k] = 16'(w_q[WIDX'(k * N_IN) + WIDX'(idx_q)]) * 16'(in_data);
            if (state_q == IDLE) begin
                acc_d[k] = preload_s[k] + ACC_W'(prod_s[k]);
            end else begin
                acc_d[k] = acc_q[k] + ACC_W'(prod_s[k]);
            end
            logit_d[k] = scale_sat(acc_q[k]);
        end
    end

    // Weight storage; writes land only while no vector is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) begin
                w_q[i] <= '0;
            end
        end else if (wr_weight_s) begin
            w_q[w_addr[WIDX-1:0]] <= w_data;
        end
    end

`ifdef DENSE_BIAS_EN
    // Bias storage, same write gating as the weights.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                bias_q[k] <= '0;
            end
        end else if (wr_bias_s) begin
            bias_q[bias_off_s[1:0]] <= w_data;
        end
    end
`endif

    // Vector sequencer with accumulators, index and registered logits/out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                acc_q[k]   <= '0;
                logit_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs_s) begin
                        for (int k = 0; k < 4; k++) begin
                            acc_q[k] <= acc_d[k];
                        end
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ACC;
                    end else begin
                        for (int k = 0; k < 4; k++) begin
                            acc_q[k] <= preload_s[k];
                        end
                        idx_q <= '0;
                    end
                end
                ACC: begin
                    if (hs_s) begin
                        for (int k = 0; k < 4; k++) begin
                            acc_q[k] <= acc_d[k];
                        end
                        if (idx_q == IW'(N_IN - 1)) begin
                            idx_q   <= '0;
                            state_q <= SCALE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                SCALE: begin
                    for (int k = 0; k < 4; k++) begin
                        logit_q[k] <= logit_d[k];
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        for (int k = 0; k < 4; k++) begin
                            acc_q[k] <= preload_s[k];
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    idx_q       <= '0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_logit_layer.sv
// Scoreboard bench for dense_logit_layer: directed vectors push expected logits, a monitor pops on output handshake.
module tb_dense_logit_layer;

    localparam int N_IN = 8;
    localparam int AW   = $clog2(4 * N_IN + 4);

    logic              clk;
    logic              rst;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic signed [7:0] w_data;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] logit0, logit1, logit2, logit3;
    logic              busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_got;
    logic [31:0] mon_exp;

    dense_logit_layer #(.N_IN(N_IN), .ACC_W(20), .SHIFT(7)) dut (
        .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .logit0(logit0), .logit1(logit1), .logit2(logit2), .logit3(logit3),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(a), 8'(b), 8'(c), 8'(d)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one comparison per output handshake, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_got = {logit0, logit1, logit2, logit3};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL logits: got %h expected %h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic write_w(input int addr, input int data);
        w_we   = 1'b1;
        w_addr = AW'(addr);
        w_data = 8'(data);
        @(posedge clk); #1;
        w_we   = 1'b0;
    endtask

    task automatic set_rows(input int r0, input int r1, input int r2, input int r3);
        for (int i = 0; i < N_IN; i++) begin
            write_w(0 * N_IN + i, r0);
            write_w(1 * N_IN + i, r1);
            write_w(2 * N_IN + i, r2);
            write_w(3 * N_IN + i, r3);
        end
    endtask

    // Stream count copies of val; optionally pulse a weight write in the cycle element wr_at is offered.
    task automatic send(input int val, input int count, input int wr_at, input int waddr, input int wdata);
        int n;
        int cyc;
        bit wrote;
        n = 0; cyc = 0; wrote = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'(val);
        while (n < count && cyc < 200) begin
            w_we   = (wr_at >= 0) && !wrote && (n == wr_at);
            w_addr = AW'(waddr);
            w_data = 8'(wdata);
            if (w_we) wrote = 1'b1;
            if (in_ready) n++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        w_we     = 1'b0;
        chk("elements_accepted", n, count);
    endtask

    task automatic wait_out();
        int c;
        c = 0;
        while (!out_valid && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("out_valid_seen", int'(out_valid), 1);
    endtask

    task automatic finish_vec();
        wait_out();
        @(posedge clk); #1;
    endtask

    initial begin
        int c;
        rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_logits", int'({logit0, logit1, logit2, logit3}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic MAC with exact latency checks.
        set_rows(64, -64, 0, 127);
        exp_q.push_back(pack4(8, -8, 0, 15));
        send(2, 8, -1, 0, 0);
        chk("scale_out_valid", int'(out_valid), 0);
        chk("scale_busy", int'(busy), 1);
        chk("scale_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("latency_out_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        chk("idle_after_hs", int'(busy), 0);

        // Saturation both ways.
        set_rows(127, -128, 0, 0);
        exp_q.push_back(pack4(127, -128, 0, 0));
        send(127, 8, -1, 0, 0);
        finish_vec();

        // Backpressure in HOLD with in_valid asserted.
        out_ready = 1'b0;
        exp_q.push_back(pack4(7, -8, 0, 0));
        send(1, 8, -1, 0, 0);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'sd5;
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_logit1", int'(logit1), -8);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_backpressure", int'(busy), 0);
        exp_q.push_back(pack4(7, -8, 0, 0));
        send(1, 8, -1, 0, 0);
        finish_vec();

        // Reset mid-vector clears everything including weights.
        send(1, 3, -1, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_logits", int'({logit0, logit1, logit2, logit3}), 0);
        chk("midrst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(pack4(0, 0, 0, 0));
        send(50, 8, -1, 0, 0);
        finish_vec();

        // Weight write gating: busy write ignored, idle write lands, same-cycle write uses old weight.
        set_rows(16, 0, 0, 0);
        exp_q.push_back(pack4(8, 0, 0, 0));
        send(8, 8, 3, 0, 100);
        finish_vec();
        exp_q.push_back(pack4(8, 0, 0, 0));
        send(8, 8, -1, 0, 0);
        finish_vec();
        write_w(0, 100);
        exp_q.push_back(pack4(13, 0, 0, 0));
        send(8, 8, 0, 0, 16);
        finish_vec();
        exp_q.push_back(pack4(8, 0, 0, 0));
        send(8, 8, -1, 0, 0);
        finish_vec();

        // Bias (if compiled in) plus floor rounding of a small negative sum.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        write_w(4 * N_IN + 0, 5);
        write_w(4 * N_IN + 1, -3);
        for (int i = 0; i < N_IN; i++) write_w(2 * N_IN + i, -1);
`ifdef DENSE_BIAS_EN
        exp_q.push_back(pack4(5, -3, -1, 0));
`else
        exp_q.push_back(pack4(0, 0, -1, 0));
`endif
        send(9, 8, -1, 0, 0);
        finish_vec();

        c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
